// File: rtl/spike_time_encoder.sv
// spike_time_encoder
//   Transmitter side of the kwta spike interface. Turns a vector of small
//   integers into temporally coded spikes: once per gamma cycle every enabled
//   channel fires, and a smaller value fires earlier. The load port is
//   double-buffered, so the next vector can wait in a shadow buffer while the
//   current gamma cycle plays out. A full shadow buffer at the end of a gamma
//   cycle starts the next cycle with no gap.
//
//   Build option:
//     FALLING_EDGE_EN  defined   -> output_spikes is active-low (idle '1)
//                      undefined -> output_spikes is active-high (idle '0)
//
// Ports
//   aclk          in   clock, rising edge
//   grst          in   asynchronous reset, active-low
//   load_valid    in   load_values / load_mask are valid
//   load_ready    out  shadow buffer empty; a load is taken when valid && ready
//   load_values   in   NUM_INPUTS x VALUE_WIDTH, channel i at [i*VALUE_WIDTH +: VALUE_WIDTH]
//   load_mask     in   1 = channel fires in its gamma cycle, 0 = silent
//   output_spikes out  registered spike bus to kwta
//   gamma_start   out  one-cycle pulse in the first cycle of each gamma cycle
//   busy          out  high while a gamma cycle is playing
module spike_time_encoder #(
  parameter int NUM_INPUTS        = 8,
  parameter int GAMMA_CYCLE_WIDTH = 16,
  parameter int PULSE_WIDTH       = 8,
  parameter int VALUE_WIDTH       = $clog2(GAMMA_CYCLE_WIDTH)
) (
  input  logic                              aclk,
  input  logic                              grst,
  input  logic                              load_valid,
  output logic                              load_ready,
  input  logic [NUM_INPUTS*VALUE_WIDTH-1:0] load_values,
  input  logic [NUM_INPUTS-1:0]             load_mask,
  output logic [NUM_INPUTS-1:0]             output_spikes,
  output logic                              gamma_start,
  output logic                              busy
);

  // Window end v+PULSE_WIDTH is formed wide enough that it can never wrap.
  localparam int                     SUM_W    = VALUE_WIDTH + $clog2(PULSE_WIDTH) + 1;
  localparam logic [VALUE_WIDTH-1:0] CNT_LAST = VALUE_WIDTH'(GAMMA_CYCLE_WIDTH - 1);
  localparam logic [SUM_W-1:0]       PW_EXT   = SUM_W'(PULSE_WIDTH);
  localparam logic [SUM_W-1:0]       GCW_EXT  = SUM_W'(GAMMA_CYCLE_WIDTH);

`ifdef FALLING_EDGE_EN
  localparam logic [NUM_INPUTS-1:0]  SPK_IDLE = '1;
`else
  localparam logic [NUM_INPUTS-1:0]  SPK_IDLE = '0;
`endif

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t                            r_state;
  logic [VALUE_WIDTH-1:0]            r_cnt;
  logic                              r_shadow_full;
  logic [NUM_INPUTS*VALUE_WIDTH-1:0] r_shadow_vals;
  logic [NUM_INPUTS-1:0]             r_shadow_mask;
  logic [NUM_INPUTS*VALUE_WIDTH-1:0] r_active_vals;
  logic [NUM_INPUTS-1:0]             r_active_mask;
  logic [NUM_INPUTS-1:0]             r_spikes;
  logic                              r_gamma_start;
  logic                              r_busy;

  logic                              w_accept;
  logic                              w_at_last;
  logic                              w_swap;
  logic                              w_next_run;
  logic [VALUE_WIDTH-1:0]            w_next_cnt;
  logic [NUM_INPUTS*VALUE_WIDTH-1:0] w_next_vals;
  logic [NUM_INPUTS-1:0]             w_next_mask;
  logic [NUM_INPUTS-1:0]             w_spk_raw;
  logic [NUM_INPUTS-1:0]             w_spk_next;

  // True when count c lies in [v, min(v+PULSE_WIDTH, GAMMA_CYCLE_WIDTH)).
  function automatic logic spike_on(input logic [VALUE_WIDTH-1:0] v,
                                    input logic                   m,
                                    input logic [VALUE_WIDTH-1:0] c);
    logic [SUM_W-1:0] sum;
    logic [SUM_W-1:0] lim;
    sum = SUM_W'(v) + PW_EXT;
    lim = (sum < GCW_EXT) ? sum : GCW_EXT;
    return m && (SUM_W'(c) >= SUM_W'(v)) && (SUM_W'(c) < lim);
  endfunction

  assign load_ready    = ~r_shadow_full;
  assign output_spikes = r_spikes;
  assign gamma_start   = r_gamma_start;
  assign busy          = r_busy;

  assign w_accept  = load_valid & ~r_shadow_full;
  assign w_at_last = (r_state == S_RUN) && (r_cnt == CNT_LAST);
  // Shadow moves to active when idle, or at the last count of a running cycle.
  assign w_swap    = r_shadow_full && ((r_state == S_IDLE) || w_at_last);

  assign w_next_run  = w_swap || ((r_state == S_RUN) && !w_at_last);
  assign w_next_cnt  = ((r_state == S_RUN) && !w_at_last) ? r_cnt + VALUE_WIDTH'(1) : '0;
  assign w_next_vals = w_swap ? r_shadow_vals : r_active_vals;
  assign w_next_mask = w_swap ? r_shadow_mask : r_active_mask;

  // Spikes are evaluated against the next-state count and buffer so the
  // registered bus lines up with gamma_cnt in the cycle it is visible.
  always_comb begin
    w_spk_raw = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      w_spk_raw[i] = w_next_run &&
                     spike_on(w_next_vals[i*VALUE_WIDTH +: VALUE_WIDTH],
                              w_next_mask[i], w_next_cnt);
    end
  end

`ifdef FALLING_EDGE_EN
  assign w_spk_next = ~w_spk_raw;
`else
  assign w_spk_next = w_spk_raw;
`endif

  // Control FSM and registered outputs
  always_ff @(posedge aclk or negedge grst) begin
    if (!grst) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_shadow_full <= 1'b0;
      r_spikes      <= SPK_IDLE;
      r_gamma_start <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_state       <= w_next_run ? S_RUN : S_IDLE;
      r_cnt         <= w_next_cnt;
      r_shadow_full <= w_accept | (r_shadow_full & ~w_swap);
      r_spikes      <= w_spk_next;
      r_gamma_start <= w_next_run && (w_next_cnt == '0);
      r_busy        <= w_next_run;
    end
  end

  // Buffer data; validity is carried by r_shadow_full and r_state, so no reset.
  always_ff @(posedge aclk) begin
    if (w_accept) begin
      r_shadow_vals <= load_values;
      r_shadow_mask <= load_mask;
    end
    if (w_swap) begin
      r_active_vals <= r_shadow_vals;
      r_active_mask <= r_shadow_mask;
    end
  end

endmodule

// File: tb/tb_spike_time_encoder.sv
module tb_spike_time_encoder;

  localparam int NI = 8;
  localparam int VW = 4;

`ifdef FALLING_EDGE_EN
  localparam logic [NI-1:0] IDLE_SPK = '1;
`else
  localparam logic [NI-1:0] IDLE_SPK = '0;
`endif

  logic             aclk = 1'b0;
  logic             grst = 1'b0;
  logic             load_valid = 1'b0;
  logic             load_ready;
  logic [NI*VW-1:0] load_values = '0;
  logic [NI-1:0]    load_mask = '0;
  logic [NI-1:0]    output_spikes;
  logic             gamma_start;
  logic             busy;

  int checks = 0;
  int failures = 0;
  int busy_cnt = 0;
  int gs_cnt = 0;
  int busy_falls = 0;
  logic prev_busy = 1'b0;
  logic [NI:0] sb_q[$];

  always #5 aclk = ~aclk;

  spike_time_encoder dut (
    .aclk(aclk), .grst(grst), .load_valid(load_valid), .load_ready(load_ready),
    .load_values(load_values), .load_mask(load_mask),
    .output_spikes(output_spikes), .gamma_start(gamma_start), .busy(busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected spike bus for one count: fire in [v, min(v+8, 16)) if masked in.
  function automatic logic [NI-1:0] exp_spikes(input logic [NI*VW-1:0] vals,
                                               input logic [NI-1:0] mask, input int c);
    logic [NI-1:0] r;
    r = '0;
    for (int i = 0; i < NI; i++) begin
      int v;
      int hi;
      v  = int'(vals[i*VW +: VW]);
      hi = (v + 8 > 16) ? 16 : v + 8;
      r[i] = mask[i] && (c >= v) && (c < hi);
    end
    return r ^ IDLE_SPK;
  endfunction

  task automatic push_vector(input logic [NI*VW-1:0] vals, input logic [NI-1:0] mask);
    for (int c = 0; c < 16; c++) sb_q.push_back({(c == 0), exp_spikes(vals, mask, c)});
  endtask

  // Issue a load, wait (bounded) for ready, return how many edges it stalled.
  task automatic load(input logic [NI*VW-1:0] vals, input logic [NI-1:0] mask, output int waited);
    waited = 0;
    push_vector(vals, mask);
    load_values = vals;
    load_mask   = mask;
    load_valid  = 1'b1;
    while (!load_ready && waited < 200) begin
      @(posedge aclk); #1;
      waited++;
    end
    if (waited >= 200) begin
      checks++; failures++;
      $display("FAIL load_timeout: got ready=0 expected ready=1");
    end
    @(posedge aclk); #1;
    load_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 100) begin
      @(posedge aclk); #1;
      n++;
    end
    if (n >= 100) begin
      checks++; failures++;
      $display("FAIL %s: got busy=1 after 100 cycles expected busy=0", name);
    end
  endtask

  // Monitor: every cycle the DUT presents a busy sample, pop and compare.
  initial begin
    logic [NI:0] e;
    forever begin
      @(negedge aclk);
      if (busy === 1'b1) begin
        busy_cnt++;
        if (gamma_start === 1'b1) gs_cnt++;
        if (sb_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL sb_underflow: got busy sample %0h expected none", {gamma_start, output_spikes});
        end else begin
          e = sb_q.pop_front();
          check("play", {23'd0, gamma_start, output_spikes}, {23'd0, e});
        end
      end
      if (prev_busy && !busy) busy_falls++;
      prev_busy = busy;
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int w;
    int bc0, gs0, bf0;

    // 1. Reset holds outputs at idle values.
    for (int k = 0; k < 3; k++) begin
      @(posedge aclk); #1;
      check("rst_spikes", {24'd0, output_spikes}, {24'd0, IDLE_SPK});
      check("rst_ready", {31'd0, load_ready}, 32'd1);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_gs", {31'd0, gamma_start}, 32'd0);
    end
    grst = 1'b1;
    repeat (2) @(posedge aclk);
    #1;

    // 2. Single channel, v0=0: first RUN cycle two edges after acceptance.
    load(32'h0000_0000, 8'h01, w);
    check("t2_busy_pre", {31'd0, busy}, 32'd0);
    check("t2_ready_drop", {31'd0, load_ready}, 32'd0);
    @(posedge aclk); #1;
    check("t2_gs", {31'd0, gamma_start}, 32'd1);
    check("t2_busy", {31'd0, busy}, 32'd1);
    check("t2_spk0", {24'd0, output_spikes}, {24'd0, 8'h01 ^ IDLE_SPK});
    check("t2_ready_back", {31'd0, load_ready}, 32'd1);
    wait_idle("t2_idle");
    check("t2_idle_spk", {24'd0, output_spikes}, {24'd0, IDLE_SPK});

    // 3. Ordering: v3=1 v7=2 v6=3 v2=4 v0=5; with ch6 enabled and without.
    load(32'h2300_1405, 8'hCD, w);
    @(posedge aclk); #1;
    wait_idle("t3a_idle");
    load(32'h2300_1405, 8'h8D, w);
    @(posedge aclk); #1;
    wait_idle("t3b_idle");

    // 4. Clip and ties: v1=v4=v5=14, v6=15.
    load(32'h0FEE_00E0, 8'h72, w);
    @(posedge aclk); #1;
    wait_idle("t4_idle");
    check("t4_idle_spk", {24'd0, output_spikes}, {24'd0, IDLE_SPK});

    // 5. Back-to-back: three vectors, third stalls until the first swap-out.
    @(negedge aclk); #1;
    bc0 = busy_cnt; gs0 = gs_cnt; bf0 = busy_falls;
    load(32'h7654_3210, 8'hFF, w);
    load(32'h0123_4567, 8'hA5, w);
    check("t5_b_wait", w, 32'd1);
    check("t5_ready_full", {31'd0, load_ready}, 32'd0);
    load(32'hFFFF_0000, 8'h0F, w);
    check("t5_c_stall", w, 32'd15);
    wait_idle("t5_idle");
    @(negedge aclk); #1;
    check("t5_busy_cycles", busy_cnt - bc0, 32'd48);
    check("t5_gamma_starts", gs_cnt - gs0, 32'd3);
    check("t5_no_gap", busy_falls - bf0, 32'd1);

    // 6. Reset mid-cycle with spikes high and a vector queued.
    load(32'h0000_0000, 8'hFF, w);
    load(32'h1111_1111, 8'hFF, w);
    repeat (5) @(posedge aclk);
    #1;
    check("t6_spk_cnt6", {24'd0, output_spikes}, {24'd0, 8'hFF ^ IDLE_SPK});
    #2;
    grst = 1'b0;
    #1;
    sb_q.delete();
    check("t6_spk_rst", {24'd0, output_spikes}, {24'd0, IDLE_SPK});
    check("t6_busy_rst", {31'd0, busy}, 32'd0);
    check("t6_ready_rst", {31'd0, load_ready}, 32'd1);
    check("t6_gs_rst", {31'd0, gamma_start}, 32'd0);
    repeat (2) @(posedge aclk);
    #1;
    grst = 1'b1;
    bc0 = busy_cnt;
    repeat (20) @(posedge aclk);
    #1;
    check("t6_queue_lost", busy_cnt - bc0, 32'd0);
    check("t6_spk_idle", {24'd0, output_spikes}, {24'd0, IDLE_SPK});

    check("sb_drained", sb_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
